// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: MIPS pipeline sequencer/hazard unit; ports: clk/reset, ID/EX hazard fields, mispredict, halt_detected, dbg_run/step/stop in; latch enables/flushes, halted, state_out, cycle_count out
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           id_rs,
    input  logic [4:0]           id_rt,
    input  logic                 id_uses_rs,
    input  logic                 id_uses_rt,
    input  logic                 ex_mem_read,
    input  logic [4:0]           ex_rt,
    input  logic                 mispredict,
    input  logic                 halt_detected,
    input  logic                 dbg_run,
    input  logic                 dbg_step,
    input  logic                 dbg_stop,
    output logic                 pipe_enable,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 halted,
    output logic [2:0]           state_out,
    output logic [CNT_WIDTH-1:0] cycle_count
);
    typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, STEP = 3'd2, DRAIN = 3'd3, HALTED = 3'd4} state_t;
    state_t     state, next_state;
    logic [3:0] drain_cnt;
    logic       load_use, take_halt;

    assign load_use  = ex_mem_read && ex_rt != 5'd0 &&
                       ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    assign take_halt = halt_detected && !mispredict;
    assign halted    = state == HALTED;
    assign state_out = state;

    always_comb begin
        pipe_enable = 1'b0;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        next_state  = state;
        case (state)
            IDLE: next_state = dbg_run ? RUN : dbg_step ? STEP : IDLE;
            RUN, STEP: begin
                pipe_enable = 1'b1;
                pc_write    = mispredict || !load_use;
                if_id_write = mispredict || !load_use;
                if_id_flush = mispredict;
                id_ex_flush = mispredict || load_use;
                next_state  = take_halt ? DRAIN : (state == STEP || dbg_stop) ? IDLE : RUN;
            end
            DRAIN: begin
                pipe_enable = 1'b1;
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
                next_state  = drain_cnt == 4'd0 ? HALTED : DRAIN;
            end
            HALTED:  next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            drain_cnt   <= 4'd0;
            cycle_count <= '0;
        end else begin
            state       <= next_state;
            drain_cnt   <= (next_state == DRAIN && state != DRAIN) ? 4'(DRAIN_CYCLES - 1) :
                           (state == DRAIN && drain_cnt != 4'd0) ? drain_cnt - 4'd1 : drain_cnt;
            cycle_count <= cycle_count + CNT_WIDTH'(pipe_enable && cycle_count != '1);
        end
    end
endmodule
